// File: rtl/fw_verdict_pkg.sv
// fw_verdict_pkg: shared default widths, verdict encoding and FSM states for the verdict enforcer
package fw_verdict_pkg;
  localparam int DATA_W_DEF = 256;
  localparam int USER_W_DEF = 12;
  localparam int ID_W_DEF = 3;
  localparam int VERDICT_BIT_DEF = 0;
  localparam bit PASS_VALUE_DEF = 1'b1;
  localparam int CNT_W_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_e;
endpackage

// File: rtl/fw_verdict_enforcer_if.sv
// fw_verdict_enforcer_if: AXI-Stream bundle between the data FIFO, the enforcer and the shell
interface fw_verdict_enforcer_if
  import fw_verdict_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int USER_W = USER_W_DEF,
  parameter int ID_W = ID_W_DEF
);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0] tuser;
  logic [ID_W-1:0] tid;
  modport master(output tvalid, tdata, tkeep, tlast, tuser, tid, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, tuser, tid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered AXI-Stream stage, full throughput, one cycle of latency
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, push, load;
  logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  // the skid register only fills while the output register is stalled, so it doubles as "full"
  always_comb begin
    push = in_valid && !skid_valid_q;
    load = !out_valid_q || out_ready;
    out_valid_d = load ? (skid_valid_q || push) : 1'b1;
    out_data_d = !load ? out_data_q : skid_valid_q ? skid_data_q : push ? in_data : out_data_q;
    skid_valid_d = !load && (skid_valid_q || push);
    skid_data_d = (!load && push) ? in_data : skid_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end
  assign in_ready = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: rtl/fw_verdict_enforcer.sv
// fw_verdict_enforcer: forwards classify-pass packets to sbu2cxp, silently drops the rest,
// gates packet starts on lossy credits and counts passed/dropped packets.
module fw_verdict_enforcer
  import fw_verdict_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int USER_W = USER_W_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int VERDICT_BIT = VERDICT_BIT_DEF,
  parameter bit PASS_VALUE = PASS_VALUE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  fw_verdict_enforcer_if.slave    s_axis,
  fw_verdict_enforcer_if.master   m_axis,
  input  logic                    has_credits,
  input  logic                    clear_counters,
  output logic [CNT_W-1:0]        pass_pkts,
  output logic [CNT_W-1:0]        drop_pkts
);
  localparam int PW = DATA_W + DATA_W / 8 + 1 + USER_W + ID_W;
  state_e state_q, state_d;
  logic [CNT_W-1:0] pass_q, pass_d, drop_q, drop_d;
  logic ready, skid_ready, skid_valid, is_pass, accept, push;
  logic [USER_W-1:0] user_clr;
  logic [PW-1:0] out_payload;
  // IDLE is exactly the start-of-packet position; credits are only consulted there
  always_comb begin
    is_pass = s_axis.tuser[VERDICT_BIT] == PASS_VALUE;
    ready = ap_rst_n && (state_q == FWD ? skid_ready : state_q == DROP ? 1'b1 :
            s_axis.tvalid && (!is_pass || (has_credits && skid_ready)));
    accept = s_axis.tvalid && ready;
    push = accept && (state_q == FWD || (state_q == IDLE && is_pass));
    state_d = !accept ? state_q : s_axis.tlast ? IDLE : state_q != IDLE ? state_q : is_pass ? FWD : DROP;
    pass_d = clear_counters ? '0 : (push && s_axis.tlast && !(&pass_q)) ? pass_q + CNT_W'(1) : pass_q;
    drop_d = clear_counters ? '0 : (accept && !push && s_axis.tlast && !(&drop_q)) ? drop_q + CNT_W'(1) : drop_q;
    user_clr = s_axis.tuser;
    user_clr[VERDICT_BIT] = 1'b0;
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      pass_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q <= pass_d;
      drop_q <= drop_d;
    end
  end
  axis_skid_buffer #(.W(PW)) u_skid (
    .clk       (ap_clk),
    .rst       (!ap_rst_n),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .in_data   ({s_axis.tdata, s_axis.tkeep, s_axis.tlast, user_clr, s_axis.tid}),
    .out_valid (skid_valid),
    .out_ready (m_axis.tready),
    .out_data  (out_payload)
  );
  assign s_axis.tready = ready;
  assign m_axis.tvalid = skid_valid && ap_rst_n;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser, m_axis.tid} = out_payload;
  assign pass_pkts = pass_q;
  assign drop_pkts = drop_q;
endmodule

// File: tb/tb_fw_verdict_enforcer.sv
// tb_fw_verdict_enforcer: random packet traffic against a packet-level reference model,
// plus a 2-bit-counter instance sharing the stimulus to exercise saturation.
module tb_fw_verdict_enforcer;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 12;
  localparam int IW = 3;
  localparam int VB = 0;
  localparam int PW = DW + KW + 1 + UW + IW;
  localparam longint SAT32 = 64'hFFFF_FFFF;
  logic ap_clk, ap_rst_n, has_credits, clear_counters;
  logic [31:0] pass_pkts, drop_pkts;
  logic [1:0] pass_sat, drop_sat;
  fw_verdict_enforcer_if s ();
  fw_verdict_enforcer_if m ();
  fw_verdict_enforcer_if s2 ();
  fw_verdict_enforcer_if m2 ();
  assign s2.tvalid = s.tvalid;
  assign s2.tdata = s.tdata;
  assign s2.tkeep = s.tkeep;
  assign s2.tlast = s.tlast;
  assign s2.tuser = s.tuser;
  assign s2.tid = s.tid;
  assign m2.tready = m.tready;
  fw_verdict_enforcer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_axis(s), .m_axis(m),
    .has_credits(has_credits), .clear_counters(clear_counters),
    .pass_pkts(pass_pkts), .drop_pkts(drop_pkts)
  );
  fw_verdict_enforcer #(.CNT_W(2)) dut_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_axis(s2), .m_axis(m2),
    .has_credits(has_credits), .clear_counters(clear_counters),
    .pass_pkts(pass_sat), .drop_pkts(drop_sat)
  );
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // m-side ready pattern and credit source, applied 2 time units after each edge
  int mode = 0;
  int ph = 0;
  bit cred_rand = 0;
  bit cred_hold = 1;
  always @(posedge ap_clk) begin
    #2;
    ph++;
    m.tready = mode == 0 ? 1'b1 : mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) :
               mode == 2 ? ($urandom_range(0, 1) == 1) : 1'b0;
    has_credits = cred_rand ? ($urandom_range(0, 3) != 0) : cred_hold;
  end
  // reference model: packet-level view of a 2-deep forwarding buffer and two counters
  logic [PW-1:0] q[$];
  logic [PW-1:0] bt;
  int occ;
  bit v, exp_rdy;
  bit sop = 1;
  bit pkt_pass = 0;
  longint cnt_p = 0;
  longint cnt_d = 0;
  always @(negedge ap_clk) begin
    occ = q.size();
    v = s.tuser[VB] == 1'b1;
    exp_rdy = !ap_rst_n ? 1'b0 : !sop ? (!pkt_pass || occ < 2) :
              (s.tvalid && (!v || (has_credits && occ < 2)));
    check("s_tready", 320'(s.tready), 320'(exp_rdy));
    check("m_tvalid", 320'(m.tvalid), 320'(ap_rst_n && occ > 0));
    if (ap_rst_n && occ > 0)
      check("m_beat", 320'({m.tdata, m.tkeep, m.tlast, m.tuser, m.tid}), 320'(q[0]));
    check("pass_pkts", 320'(pass_pkts), 320'(cnt_p > SAT32 ? SAT32 : cnt_p));
    check("drop_pkts", 320'(drop_pkts), 320'(cnt_d > SAT32 ? SAT32 : cnt_d));
    check("pass_sat", 320'(pass_sat), 320'(cnt_p > 3 ? 3 : cnt_p));
    check("drop_sat", 320'(drop_sat), 320'(cnt_d > 3 ? 3 : cnt_d));
    if (!ap_rst_n) begin
      q.delete();
      sop = 1;
      cnt_p = 0;
      cnt_d = 0;
    end else begin
      if (occ > 0 && m.tready) void'(q.pop_front());
      if (s.tvalid && s.tready) begin
        if (sop) pkt_pass = v;
        if (pkt_pass) begin
          bt = {s.tdata, s.tkeep, s.tlast, s.tuser, s.tid};
          bt[IW + VB] = 1'b0;
          q.push_back(bt);
          if (s.tlast) cnt_p++;
        end else if (s.tlast) cnt_d++;
        sop = s.tlast;
      end
      if (clear_counters) begin
        cnt_p = 0;
        cnt_d = 0;
      end
    end
  end
  task automatic accept(output int w);
    w = 0;
    @(negedge ap_clk);
    while (!s.tready && w < 300) begin
      w++;
      @(negedge ap_clk);
    end
    if (w >= 300) check("accept_timeout", 320'(w), 320'(0));
    @(posedge ap_clk);
    #1;
    s.tvalid = 1'b0;
  endtask
  task automatic beat(input logic [UW-1:0] u, input bit last, output int w);
    for (int i = 0; i < DW / 32; i++) s.tdata[i*32 +: 32] = $urandom;
    s.tkeep = KW'($urandom);
    s.tlast = last;
    s.tuser = u;
    s.tid = IW'($urandom);
    s.tvalid = 1'b1;
    accept(w);
  endtask
  task automatic send_pkt(input int len, input bit pass, input bit cred_off, output int waited);
    int w;
    logic [UW-1:0] u;
    waited = 0;
    for (int b = 0; b < len; b++) begin
      u = UW'($urandom);
      if (b == 0) u[VB] = pass;
      beat(u, b == len - 1, w);
      waited += w;
      if (b == 0 && cred_off) cred_hold = 0;
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    mode = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge ap_clk);
      n++;
    end
    @(posedge ap_clk);
    #1;
    check("drain_empty", 320'(q.size()), 320'(0));
  endtask
  initial begin
    int w;
    ap_rst_n = 1'b0;
    clear_counters = 1'b0;
    s.tvalid = 1'b0;
    s.tdata = '0;
    s.tkeep = '0;
    s.tlast = 1'b0;
    s.tuser = '0;
    s.tid = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_s_tready", 320'(s.tready), 320'(0));
    check("rst_m_tvalid", 320'(m.tvalid), 320'(0));
    check("rst_m_data", 320'({m.tdata, m.tkeep, m.tlast, m.tuser, m.tid}), 320'(0));
    check("rst_pass", 320'(pass_pkts), 320'(0));
    check("rst_drop", 320'(drop_pkts), 320'(0));
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    send_pkt(3, 1, 0, w);
    drain();
    check("t1_pass", 320'(pass_pkts), 320'(1));
    check("t1_drop", 320'(drop_pkts), 320'(0));
    mode = 3;
    send_pkt(4, 0, 0, w);
    check("drop_no_stall", 320'(w), 320'(0));
    @(negedge ap_clk);
    check("drop_no_m_valid", 320'(m.tvalid), 320'(0));
    check("drop_count", 320'(drop_pkts), 320'(1));
    drain();
    cred_hold = 0;
    fork
      send_pkt(3, 1, 0, w);
      begin
        repeat (10) @(posedge ap_clk);
        #1;
        cred_hold = 1;
      end
    join
    check("cred_stall", 320'(w >= 10), 320'(1));
    send_pkt(5, 1, 1, w);
    check("cred_mid_pkt", 320'(w), 320'(0));
    cred_hold = 1;
    drain();
    check("cred_pass", 320'(pass_pkts), 320'(3));
    mode = 1;
    for (int i = 0; i < 16; i++) send_pkt(1, i % 2 == 0, 0, w);
    drain();
    check("b2b_pass", 320'(pass_pkts), 320'(11));
    check("b2b_drop", 320'(drop_pkts), 320'(9));
    mode = 2;
    cred_rand = 1;
    for (int i = 0; i < 40; i++) send_pkt($urandom_range(1, 4), $urandom_range(0, 1) == 1, 0, w);
    cred_rand = 0;
    drain();
    clear_counters = 1'b1;
    send_pkt(1, 0, 0, w);
    clear_counters = 1'b0;
    @(negedge ap_clk);
    check("clr_drop", 320'(drop_pkts), 320'(0));
    check("clr_pass", 320'(pass_pkts), 320'(0));
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < 4; i++) send_pkt(2, 1, 0, w);
    drain();
    check("sat_small_pass", 320'(pass_sat), 320'(3));
    check("sat_wide_pass", 320'(pass_pkts), 320'(4));
    beat(12'h001, 0, w);
    for (int i = 0; i < DW / 32; i++) s.tdata[i*32 +: 32] = $urandom;
    s.tlast = 1'b0;
    s.tuser = 12'h001;
    s.tvalid = 1'b1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    check("midrst_m_tvalid", 320'(m.tvalid), 320'(0));
    check("midrst_pass", 320'(pass_pkts), 320'(0));
    check("midrst_drop", 320'(drop_pkts), 320'(0));
    accept(w);
    for (int b = 0; b < 3; b++) beat(UW'($urandom), b == 2, w);
    drain();
    check("midrst_new_pkt", 320'(pass_pkts), 320'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fw_verdict_enforcer.md
Name: fw_verdict_enforcer

Overview:
- Consumer side of the firewall classification tag: reads the per-packet verdict carried in tuser[VERDICT_BIT] of the classified stream leaving the store-and-forward FIFO.
- Forwards allowed packets to sbu2cxp and silently drops denied ones.
- Gates packet starts on the shell's lossy credit indication and keeps pass/drop packet counters for host readout.
- Sits between the sbu2cxp data FIFO master port and the sbu2cxp shell port.

Parameters:
- DATA_W, 256, tdata width (tkeep = DATA_W/8).
- USER_W, 12, tuser width.
- ID_W, 3, tid width.
- VERDICT_BIT, 0, tuser bit holding the classify verdict.
- PASS_VALUE, 1, verdict value meaning "forward"; the other value means "drop".
- CNT_W, 32, counter width.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous reset, active low.
- s_axis_tvalid  in  1  classified stream valid.
- s_axis_tready  out  1  classified stream ready.
- s_axis_tdata  in  DATA_W  data.
- s_axis_tkeep  in  DATA_W/8  byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tuser  in  USER_W  user bits; verdict at VERDICT_BIT.
- s_axis_tid  in  ID_W  stream id.
- m_axis_tvalid  out  1  to sbu2cxp.
- m_axis_tready  in  1  from sbu2cxp.
- m_axis_tdata  out  DATA_W  data.
- m_axis_tkeep  out  DATA_W/8  byte enables.
- m_axis_tlast  out  1  end of packet.
- m_axis_tuser  out  USER_W  user bits; VERDICT_BIT forced to 0.
- m_axis_tid  out  ID_W  stream id.
- has_credits  in  1  cxp2sbu_lossy_has_credits.
- clear_counters  in  1  one-cycle pulse; zeroes both counters.
- pass_pkts  out  CNT_W  forwarded packet count.
- drop_pkts  out  CNT_W  dropped packet count.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - FSM goes to IDLE and the skid buffer empties.
  - m_axis_tvalid=0, s_axis_tready=0 during reset.
  - pass_pkts=0, drop_pkts=0; all m_axis data outputs 0.
- Start of packet (SOP): the first accepted beat after reset, and every beat following an accepted tlast beat.
- FSM states IDLE, FWD, DROP.
- IDLE:
  - s_axis_tready=0 unless an SOP beat can be consumed this cycle.
  - SOP beat with verdict==PASS_VALUE, has_credits=1 and skid space available: beat is accepted and pushed to the skid buffer; go to FWD, or stay in IDLE if tlast=1.
  - SOP beat with verdict!=PASS_VALUE: beat is accepted immediately (tready=1, independent of credits and of m_axis_tready) and discarded; go to DROP, or stay in IDLE if tlast=1.
  - Pass SOP with has_credits=0: stall with tready=0 and no beat consumed. Credits are sampled only at SOP.
- FWD:
  - s_axis_tready = skid buffer not full. Each accepted beat is pushed to the skid buffer.
  - Accepted tlast returns the FSM to IDLE.
  - has_credits is ignored mid-packet.
  - Verdict bits on non-SOP beats are ignored.
- DROP:
  - s_axis_tready=1; beats are consumed and discarded.
  - Accepted tlast returns the FSM to IDLE.
- Skid buffer:
  - 2-entry, registered outputs, full throughput of 1 beat/cycle.
  - Latency 1 cycle from s-side acceptance to m_axis_tvalid.
  - m_axis_* stable while tvalid=1 and tready=0.
  - All fields pass unchanged except tuser[VERDICT_BIT]=0.
- Counters:
  - pass_pkts increments on a tlast beat pushed in FWD or IDLE-pass; drop_pkts increments on a tlast beat consumed on the drop path.
  - Both counters saturate at all-ones.
  - clear_counters has priority: a coincident increment is lost and the result is 0.
- Boundary cases:
  - A single-beat packet both decides and ends in the same cycle.
  - Back-to-back packets allow no idle cycle between a tlast beat and the next SOP beat.
  - If the skid buffer is full in IDLE, a pass SOP stalls.
  - A drop SOP never stalls on the m side.
  - Reset mid-packet: the first beat after reset is treated as SOP. The upstream FIFO shares this reset.

Decomposition:
- Package fw_verdict_pkg holds:
  - Default widths.
  - VERDICT_BIT and PASS_VALUE defaults.
  - FSM state encoding: IDLE=2'd0, FWD=2'd1, DROP=2'd2.
- Sub-module axis_skid_buffer: generic 2-entry registered AXI-Stream stage over {tdata, tkeep, tlast, tuser, tid}. It is reused by later shell-side blocks.

Test Plan:
- Pass single packet: 3 beats with SOP tuser=0x001, has_credits=1, m_tready=1. Expect 3 beats out, first m_axis_tvalid 1 cycle after first acceptance, m_axis_tuser=0x000, pass_pkts=1, drop_pkts=0.
- Drop packet: 4 beats with SOP tuser=0x000 and m_tready=0 throughout. Expect s_axis_tready=1 for all 4 beats, no m_axis_tvalid, drop_pkts=1.
- Credit gating:
  - Pass SOP presented with has_credits=0 for 10 cycles: s_axis_tready=0 and nothing consumed.
  - has_credits rises: packet forwarded.
  - Credits dropped mid-packet: remaining beats still forwarded.
- Back-pressure and back-to-back: alternating pass/drop single-beat packets, with m_tready toggled as 1,0,0,1,… Expect data order preserved, no beat lost or duplicated, m outputs stable while stalled, counters matching the packet mix (e.g. 8 pass / 8 drop).
- Counter saturation and clear:
  - Preload via forcing to 0xFFFFFFFE; two pass packets give 0xFFFFFFFF.
  - clear_counters in the same cycle as a drop tlast leaves drop_pkts=0.
- Reset mid-packet: ap_rst_n=0 for 1 cycle during beat 2 of a 5-beat pass packet. Expect m_axis_tvalid=0 next cycle, counters 0, and the next beat treated as SOP.
